conv_psum_accum: RTL
====================

CONV_PSUM_ACCUM -- requirements
Module: conv_psum_accum

Interface
REQ-001 SHALL have parameter DW, default 32, signed width of each input partial sum and each output lane.
REQ-002 SHALL have parameter DP, default 56, lanes (output pixels) per beat.
REQ-003 SHALL have parameter CHNL_NUM, default 3, partial-sum channels summed per beat (>=1).
REQ-004 SHALL have parameter GW, default 8, accumulator guard bits; AW = DW+GW.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; data_i in CHNL_NUM*DP*DW, channel c, lane m at bits [DW*(c*DP+m)+:DW].
REQ-007 SHALL have ports: first_i in 1, beat opens a group; last_i in 1, beat closes a group.
REQ-008 SHALL have ports: bias_i in DW, signed, sampled with the last beat; relu_en in 1, sampled with the last beat.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; data_o out DP*DW, lane m at [DW*m+:DW].
REQ-010 SHALL have port err_o out 1, sticky protocol-error flag; clr_err in 1 clears it.

Function
REQ-011 SHALL accept a beat when in_valid && in_ready; global enable en = !out_valid || out_ready; in_ready = en.
REQ-012 Stage 1 (when en) SHALL register, per lane, the signed sum of all CHNL_NUM channels, sign-extended to AW, plus valid/first/last/bias/relu.
REQ-013 Stage 2 (when en and stage-1 valid) SHALL set acc = sum if first or state IDLE, else acc + sum, wrapping modulo 2^AW.
REQ-014 SHALL use a two-state FSM: IDLE (no open group), ACCUM (group open); first -> ACCUM, last -> IDLE, first&&last -> IDLE after a single-beat group.
REQ-015 A non-first beat in IDLE SHALL be treated as first and set err_o.
REQ-016 A first beat in ACCUM SHALL discard the open sum, restart the group and set err_o.
REQ-017 On a last beat, the output register SHALL load per lane: r = acc_new + sext(bias); r = 0 if relu && r<0; clamp to [-2^(DW-1), 2^(DW-1)-1]; out_valid <= 1.
REQ-018 Latency SHALL be exactly 2 cycles from last-beat acceptance to out_valid with no backpressure; throughput one beat per cycle.
REQ-019 out_valid && !out_ready SHALL hold data_o stable, deassert in_ready, and freeze both stages and the FSM.
REQ-020 Handshake on cycle with out_valid && out_ready SHALL clear out_valid unless a new result loads that same cycle (back-to-back groups).
REQ-021 Non-last beats SHALL never assert out_valid.
REQ-022 clr_err SHALL clear err_o; a simultaneous error set SHALL win.

Reset
REQ-023 rst_n low SHALL asynchronously clear stage-1 valid, acc, FSM to IDLE, out_valid=0, data_o=0, err_o=0; in_ready=1 after reset.
REQ-024 Reset mid-group SHALL discard the partial group; the next beat needs first_i.

Structure
REQ-025 The package conv_acc_pkg SHALL hold defaults for DW/DP/CHNL_NUM/GW, the FSM state enum, and the AW derivation.
REQ-026 Bias/ReLU/saturation SHALL be one sub-module psum_sat (AW in, DW out), instanced per lane.

Verification
REQ-027 Single beat first&last, CHNL_NUM=3, lane0 data {5,-2,10}, bias 3, relu 0 -> data_o lane0=16 two cycles later.
REQ-028 Group of 4 beats, lane sums 100 each, bias -500, relu 1 -> lane=0; relu 0 -> lane=-100.
REQ-029 DW=32, 3 beats of lane sum 0x7FFF_FFFF, bias 0 -> lane saturates to 0x7FFF_FFFF; negative analog -> 0x8000_0000.
REQ-030 out_ready low 5 cycles with result pending and in_valid high -> in_ready=0, data_o stable, no beat lost; after release, next group correct.
REQ-031 Beat without first in IDLE -> err_o=1, sum starts fresh; clr_err -> err_o=0.
REQ-032 Assert rst_n low mid-group, then a group with first -> result excludes pre-reset beats; all outputs 0 during reset.

Source files
------------

// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg: shared defaults, accumulator width derivation and FSM states for the psum accumulator
package conv_acc_pkg;
    localparam int DW_DEF   = 32;
    localparam int DP_DEF   = 56;
    localparam int CHNL_DEF = 3;
    localparam int GW_DEF   = 8;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic int aw_of(input int dw, input int gw);
        return dw + gw;
    endfunction
endpackage

// File: rtl/psum_sat.sv
// psum_sat: adds bias to one lane's accumulated sum, applies optional ReLU and saturates to DW bits
module psum_sat import conv_acc_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int AW = aw_of(DW_DEF, GW_DEF)
) (
    input  logic signed [AW-1:0] acc,
    input  logic signed [DW-1:0] bias,
    input  logic                 relu,
    output logic        [DW-1:0] y
);
    localparam logic signed [AW:0] MAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW:0] r, rr;

    // One extra bit so acc + bias can never wrap before clamping
    always_comb begin
        r  = (AW+1)'(acc) + (AW+1)'(bias);
        rr = (relu && r[AW]) ? '0 : r;
        y  = rr > MAX ? MAX[DW-1:0] : rr < MIN ? MIN[DW-1:0] : rr[DW-1:0];
    end
endmodule

// File: rtl/conv_psum_accum.sv
// conv_psum_accum: two-stage channel/beat partial-sum accumulator with bias, ReLU and saturation per lane
module conv_psum_accum import conv_acc_pkg::*; #(
    parameter int DW       = DW_DEF,
    parameter int DP       = DP_DEF,
    parameter int CHNL_NUM = CHNL_DEF,
    parameter int GW       = GW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHNL_NUM*DP*DW-1:0] data_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [DW-1:0]            bias_i,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DP*DW-1:0]         data_o,
    output logic                     err_o,
    input  logic                     clr_err
);
    localparam int AW = aw_of(DW, GW);

    state_t state;
    logic en, fresh, err_set;
    logic s1_valid, s1_first, s1_last, s1_relu;
    logic signed [DW-1:0] s1_bias;
    logic signed [AW-1:0] sum_c [DP];
    logic signed [AW-1:0] s1_sum [DP];
    logic signed [AW-1:0] acc [DP];
    logic signed [AW-1:0] acc_new [DP];
    logic [DW-1:0] sat_y [DP];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign fresh    = s1_first || state == IDLE;
    // Missing first in IDLE or a restart while a group is open are both protocol errors
    assign err_set  = en && s1_valid && (s1_first ? state == ACCUM : state == IDLE);

    always_comb begin
        for (int m = 0; m < DP; m++) begin
            sum_c[m] = '0;
            for (int c = 0; c < CHNL_NUM; c++)
                sum_c[m] += AW'($signed(data_i[DW*(c*DP+m)+:DW]));
            acc_new[m] = fresh ? s1_sum[m] : acc[m] + s1_sum[m];
        end
    end

    for (genvar m = 0; m < DP; m++) begin : g_lane
        psum_sat #(.DW(DW), .AW(AW)) u_sat (
            .acc  (acc_new[m]),
            .bias (s1_bias),
            .relu (s1_relu),
            .y    (sat_y[m])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_relu   <= 1'b0;
            s1_bias   <= '0;
            s1_sum    <= '{default: '0};
            acc       <= '{default: '0};
            state     <= IDLE;
            out_valid <= 1'b0;
            data_o    <= '0;
            err_o     <= 1'b0;
        end else begin
            if (en) begin
                s1_valid  <= in_valid;
                s1_first  <= first_i;
                s1_last   <= last_i;
                s1_bias   <= bias_i;
                s1_relu   <= relu_en;
                s1_sum    <= sum_c;
                out_valid <= s1_valid && s1_last;
                if (s1_valid) begin
                    acc   <= acc_new;
                    state <= s1_last ? IDLE : ACCUM;
                end
                if (s1_valid && s1_last)
                    for (int m = 0; m < DP; m++) data_o[DW*m+:DW] <= sat_y[m];
            end
            err_o <= err_set || (err_o && !clr_err);
        end
    end
endmodule
